llsc_link_ctrl: RTL

- Sequences LL/SC atomics for the MEM stage and owns the link state (LLbit plus linked address).
- On SC: decides success or failure, drives the conditional store onto the data-bus handshake, stalls the pipeline until done, and returns the 0/1 result for write-back.
- Clears the link on exception flush, ERET, matching external snoop, or timeout.

---
 rtl/llsc_link_ctrl_pkg.sv | 27 ++
 rtl/llsc_link_reg.sv | 109 ++++++++++
 rtl/llsc_link_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/llsc_link_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// llsc_link_ctrl_pkg
// Shared definitions for the LL/SC link controller:
//   - llsc_state_e     : sequencer state encoding (IDLE/CHECK/STORE/ABORT)
//   - FLUSH_CAUSE_EXC  : flush_cause value that marks an exception flush
//   - WRITE_ENABLE     : active level of register write enables
//   - granule_mask()   : address mask that clears the low lg2 bits
// -----------------------------------------------------------------------------
package llsc_link_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_STORE = 2'd2,
        S_ABORT = 2'd3
    } llsc_state_e;

    localparam logic FLUSH_CAUSE_EXC = 1'b1;
    localparam logic WRITE_ENABLE    = 1'b1;
    localparam int   MAX_ADDR_W      = 64;

    // Mask keeping only the granule-aligned part of an address.
    function automatic logic [MAX_ADDR_W-1:0] granule_mask(input int lg2);
        granule_mask = ~((64'd1 << lg2) - 64'd1);
    endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// -----------------------------------------------------------------------------
// llsc_link_reg
// Holds the LL link bit and the granule-aligned linked address, with the
// priority set/clear logic and the link timeout counter.
//   Priority on the link bit: reset > i_kill > i_ll_set > snoop/timeout/consume.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_ll_set        LL accepted this cycle
//   i_ll_addr       LL effective address
//   i_kill          exception flush or ERET
//   i_consume       SC finished and consumes the link
//   i_snoop_valid   external write observed
//   i_snoop_addr    external write address
//   o_llbit         current link bit
//   o_link_addr     granule-aligned linked address
// Build option: LLSC_ADDR_CHECK_EN keeps a real linked address and matches
// snoops by granule; without it the address is tied 0 and any snoop clears.
// -----------------------------------------------------------------------------
module llsc_link_reg
    import llsc_link_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int GRANULE_LG2  = 2,
    parameter int LINK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ll_set,
    input  logic [ADDR_W-1:0] i_ll_addr,
    input  logic              i_kill,
    input  logic              i_consume,
    input  logic              i_snoop_valid,
    input  logic [ADDR_W-1:0] i_snoop_addr,
    output logic              o_llbit,
    output logic [ADDR_W-1:0] o_link_addr
);

    localparam int CNT_W = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] GRANULE_MASK = ADDR_W'(granule_mask(GRANULE_LG2));

    logic             r_llbit;
    logic [CNT_W-1:0] r_cnt;
    logic             w_llbit_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_snoop_hit;
    logic             w_timeout;

`ifdef LLSC_ADDR_CHECK_EN
    logic [ADDR_W-1:0] r_link_addr;

    assign w_snoop_hit = i_snoop_valid && ((i_snoop_addr & GRANULE_MASK) == r_link_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_link_addr <= '0;
        end else if ((i_ll_set == WRITE_ENABLE) && !i_kill) begin
            r_link_addr <= i_ll_addr & GRANULE_MASK;
        end
    end

    assign o_link_addr = r_link_addr;
`else
    // Single-core build: no address kept, so any external write is a hit.
    logic w_unused_addr;
    assign w_unused_addr = ^{i_ll_addr, i_snoop_addr, GRANULE_MASK};
    assign w_snoop_hit   = i_snoop_valid;
    assign o_link_addr   = '0;
`endif

    // The counter value LINK_TIMEOUT-1 is the last cycle the link survives.
    assign w_timeout = (LINK_TIMEOUT != 0) && r_llbit && (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: hold values are assigned first so no path leaves a signal
        // unassigned; otherwise synthesis would infer a latch.
        w_llbit_nxt = r_llbit;
        w_cnt_nxt   = r_cnt;

        if (i_kill) begin
            w_llbit_nxt = 1'b0;
        end else if (i_ll_set) begin
            w_llbit_nxt = 1'b1;
        end else if (w_snoop_hit || w_timeout || i_consume) begin
            w_llbit_nxt = 1'b0;
        end

        // Counter restarts on LL and saturates at its last value.
        if (i_ll_set) begin
            w_cnt_nxt = '0;
        end else if (r_llbit && (r_cnt != CNT_LAST)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_llbit <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_llbit <= w_llbit_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_llbit = r_llbit;

endmodule

// File: rtl/llsc_link_ctrl.sv
// -----------------------------------------------------------------------------
// llsc_link_ctrl
// Sequences LL/SC atomics for the MEM stage. LL sets the link; SC is checked
// against the link, issues the conditional store on the data-bus handshake,
// stalls the pipeline until it resolves and returns the 0/1 result.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   ll_req, sc_req, mem_addr  MEM-stage LL pulse / held SC request, address
//   flush, flush_cause, eret  pipeline flush (cause 1 = exception), ERET
//   snoop_valid, snoop_addr   external write observed
//   bus_req / bus_ack         conditional-store handshake
//   sc_stall                  pipeline hold
//   sc_done, sc_result        registered SC completion pulse and result
//   llbit_o, link_addr_o      link state
// Build option: LLSC_ADDR_CHECK_EN enables address comparison on SC and snoop.
// -----------------------------------------------------------------------------
module llsc_link_ctrl
    import llsc_link_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int GRANULE_LG2  = 2,
    parameter int LINK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ll_req,
    input  logic              sc_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              flush,
    input  logic              flush_cause,
    input  logic              eret,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              bus_req,
    input  logic              bus_ack,
    output logic              sc_stall,
    output logic              sc_done,
    output logic              sc_result,
    output logic              llbit_o,
    output logic [ADDR_W-1:0] link_addr_o
);

    llsc_state_e       r_state;
    llsc_state_e       w_state_nxt;
    logic              r_sc_done;
    logic              r_sc_result;
    logic              w_done_nxt;
    logic              w_result_nxt;
    logic              w_consume;
    logic              w_ll_set;
    logic              w_kill;
    logic              w_any_flush;
    logic              w_match;
    logic              w_llbit;
    logic [ADDR_W-1:0] w_link_addr;

    assign w_kill      = (flush && (flush_cause == FLUSH_CAUSE_EXC)) || eret;
    assign w_any_flush = flush || eret;

`ifdef LLSC_ADDR_CHECK_EN
    localparam logic [ADDR_W-1:0] GRANULE_MASK = ADDR_W'(granule_mask(GRANULE_LG2));
    assign w_match = w_llbit && ((mem_addr & GRANULE_MASK) == w_link_addr);
`else
    assign w_match = w_llbit;
`endif

    llsc_link_reg #(
        .ADDR_W       (ADDR_W),
        .GRANULE_LG2  (GRANULE_LG2),
        .LINK_TIMEOUT (LINK_TIMEOUT)
    ) u_link_reg (
        .clk           (clk),
        .rst           (rst),
        .i_ll_set      (w_ll_set),
        .i_ll_addr     (mem_addr),
        .i_kill        (w_kill),
        .i_consume     (w_consume),
        .i_snoop_valid (snoop_valid),
        .i_snoop_addr  (snoop_addr),
        .o_llbit       (w_llbit),
        .o_link_addr   (w_link_addr)
    );

    always_comb begin
        w_state_nxt  = r_state;
        bus_req      = 1'b0;
        sc_stall     = 1'b0;
        w_done_nxt   = 1'b0;
        w_result_nxt = 1'b0;
        w_consume    = 1'b0;
        w_ll_set     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // While sc_done is up the finished SC is still presented;
                // it leaves MEM this cycle and must not restart.
                if (sc_req && !r_sc_done && !w_any_flush) begin
                    sc_stall    = 1'b1;
                    w_state_nxt = S_CHECK;
                end else if (ll_req && !sc_req) begin
                    w_ll_set = 1'b1;
                end
            end
            S_CHECK: begin
                sc_stall = 1'b1;
                if (w_any_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_match) begin
                    w_state_nxt = S_STORE;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_consume   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_STORE: begin
                bus_req  = 1'b1;
                sc_stall = 1'b1;
                // A request on the bus is never withdrawn before its ack.
                if (w_any_flush) begin
                    w_state_nxt = bus_ack ? S_IDLE : S_ABORT;
                end else if (bus_ack) begin
                    w_done_nxt   = 1'b1;
                    w_result_nxt = 1'b1;
                    w_consume    = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_ABORT: begin
                // Pipeline runs again; only the orphaned store is drained.
                bus_req  = 1'b1;
                w_ll_set = ll_req && !sc_req;
                if (bus_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sc_done   <= 1'b0;
            r_sc_result <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc_done   <= w_done_nxt;
            r_sc_result <= w_result_nxt;
        end
    end

    assign sc_done     = r_sc_done;
    assign sc_result   = r_sc_result;
    assign llbit_o     = w_llbit;
    assign link_addr_o = w_link_addr;

endmodule
